minv_host_seq: RTL

- Host-side initiator for the modular-inverse engine.
- Accepts an operand a and a modulus p as 16-bit word streams. Loads them into the engine register file digit-serially, initialises x1/x2, pulses the engine start, waits for engine ready, then streams the 256-bit inverse back out.
- Sits between the bus/stream fabric and the inversion datapath plus its control FSM.

---
 rtl/minv_pkg.sv | 13 +
 rtl/minv_word_fifo.sv | 43 ++++
 rtl/minv_host_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/minv_pkg.sv
// Shared types and constants for the modular-inverse host sequencer.
package minv_pkg;
   localparam int W     = 16;
   localparam int WORDS = 16;
   localparam int CW    = $clog2(WORDS);

   localparam logic [1:0] LD_U  = 2'd0;
   localparam logic [1:0] LD_VP = 2'd1;

   typedef enum logic [2:0] {
      IDLE, LOAD_U, LOAD_P, INIT, START, WAIT, DRAIN
   } state_t;
endpackage

// File: rtl/minv_word_fifo.sv
// Two-entry result FIFO carrying {err, last, data} with valid/ready on both sides.
module minv_word_fifo
   import minv_pkg::*;
#(
   parameter int DW = W + 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [DW-1:0] push_data,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [DW-1:0] pop_data,
   output logic [1:0]    count
);
   logic [DW-1:0] mem [2];
   logic          wr_ptr, rd_ptr;
   logic          push, pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign push       = push_valid & push_ready;
   assign pop        = pop_valid & pop_ready;
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/minv_host_seq.sv
// Host-side sequencer: loads a/p into the inverse engine, starts it, streams the result.
// Define MINV_TIMEOUT_EN to add the WAIT watchdog that aborts the engine after TIMEOUT_CYC cycles.
module minv_host_seq
   import minv_pkg::*;
`ifdef MINV_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYC = 65535
)
`endif
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_last,
   output logic          out_err,
   output logic          busy,
   output logic          ld_we,
   output logic [1:0]    ld_sel,
   output logic [CW-1:0] ld_idx,
   output logic [W-1:0]  ld_data,
   output logic          ld_init,
   output logic          minv_en,
   input  logic          minv_rdy,
   output logic          minv_abort,
   output logic          rd_en,
   output logic [CW-1:0] rd_idx,
   input  logic [W-1:0]  rd_data
);
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          zero_a, zero_a_nx, err, err_nx, abort;
   logic [CW:0]   rd_cnt;
   logic          rd_pend, rd_pend_last;
   logic          hs_in, pop, issue;
   logic          fifo_valid, push_ready;
   logic [1:0]    fifo_cnt;
   logic [W+1:0]  push_data, pop_data;

`ifdef MINV_TIMEOUT_EN
   logic [15:0] wdog;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              wdog <= '0;
      else if (state != WAIT)  wdog <= '0;
      else                     wdog <= wdog + 16'd1;
   end
`endif

   assign hs_in = in_valid & in_ready;
   assign pop   = fifo_valid & out_ready;
   // A word leaving the FIFO this cycle frees its slot at the same edge, which
   // is what lets the drain run back-to-back with out_ready held high.
   assign issue = (state == DRAIN) && !rd_cnt[CW] && push_ready &&
                  (({1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2);

   assign in_ready   = (state == IDLE) || (state == LOAD_U) || (state == LOAD_P);
   assign busy       = (state != IDLE);
   assign ld_we      = hs_in;
   assign ld_sel     = (state == LOAD_P) ? LD_VP : LD_U;
   assign ld_idx     = hs_in ? cnt : '0;
   assign ld_data    = hs_in ? in_data : '0;
   assign ld_init    = (state == INIT);
   assign minv_en    = (state == START);
   assign minv_abort = abort;
   assign rd_en      = issue & ~err;
   assign rd_idx     = rd_en ? rd_cnt[CW-1:0] : '0;
   assign push_data  = {err, rd_pend_last, rd_data & {W{~err}}};

   assign out_valid = fifo_valid;
   assign out_data  = fifo_valid ? pop_data[W-1:0] : '0;
   assign out_last  = fifo_valid & pop_data[W];
   assign out_err   = fifo_valid & pop_data[W+1];

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      zero_a_nx = zero_a;
      err_nx    = err;
      abort     = 1'b0;
      case (state)
         IDLE: if (hs_in) begin
            cnt_nx    = CW'(1);
            zero_a_nx = (in_data == '0);
            state_nx  = LOAD_U;
         end
         LOAD_U: if (hs_in) begin
            cnt_nx    = cnt + CW'(1);
            zero_a_nx = zero_a & (in_data == '0);
            if (cnt == CW'(WORDS - 1)) state_nx = LOAD_P;
         end
         LOAD_P: if (hs_in) begin
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(WORDS - 1)) begin
               if (zero_a) begin
                  state_nx = DRAIN;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = INIT;
               end
            end
         end
         INIT:  state_nx = START;
         START: state_nx = WAIT;
         WAIT: begin
            if (minv_rdy) begin
               state_nx = DRAIN;
               err_nx   = 1'b0;
            end
`ifdef MINV_TIMEOUT_EN
            else if (wdog == 16'(TIMEOUT_CYC - 1)) begin
               abort    = 1'b1;
               err_nx   = 1'b1;
               state_nx = DRAIN;
            end
`endif
         end
         DRAIN: if (pop && out_last) begin
            state_nx = IDLE;
            err_nx   = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         zero_a       <= 1'b0;
         err          <= 1'b0;
         rd_cnt       <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         zero_a       <= zero_a_nx;
         err          <= err_nx;
         rd_pend      <= issue;
         rd_pend_last <= issue && (rd_cnt[CW-1:0] == CW'(WORDS - 1));
         if (state != DRAIN) rd_cnt <= '0;
         else if (issue)     rd_cnt <= rd_cnt + (CW+1)'(1);
      end
   end

   minv_word_fifo #(.DW(W + 2)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (rd_pend),
      .push_ready (push_ready),
      .push_data  (push_data),
      .pop_valid  (fifo_valid),
      .pop_ready  (out_ready),
      .pop_data   (pop_data),
      .count      (fifo_cnt)
   );
endmodule
